// File: rtl/move_ctrl.sv
// Player move sequencer for the 16x16 tile map: reads the target tile, classifies it and
// updates position, key count and (for consumed keys/doors) the map.
module move_ctrl #(
  parameter logic [15:0] WALL_LO  = 16'd1,
  parameter logic [15:0] WALL_HI  = 16'd3,
  parameter logic [15:0] KEY_LO   = 16'd4,
  parameter logic [15:0] KEY_HI   = 16'd7,
  parameter logic [15:0] DOOR_LO  = 16'd8,
  parameter logic [15:0] DOOR_HI  = 16'd9,
  parameter logic [15:0] FLOOR_ID = 16'd0,
  parameter logic [3:0]  START_X  = 4'd1,
  parameter logic [3:0]  START_Y  = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  input  logic        level_load,
  output logic [7:0]  map_addr,
  output logic        map_rd_en,
  input  logic [15:0] map_rd_data,
  output logic        map_wr_en,
  output logic [15:0] map_wr_data,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic [3:0]  key_num,
  output logic        done,
  output logic [2:0]  result
);

  typedef enum logic [1:0] {StIdle, StRead, StWait, StApply} state_e;

  localparam logic [2:0] ResMoved      = 3'd0;
  localparam logic [2:0] ResWall       = 3'd1;
  localparam logic [2:0] ResKey        = 3'd2;
  localparam logic [2:0] ResDoorOpen   = 3'd3;
  localparam logic [2:0] ResDoorLocked = 3'd4;
  localparam logic [2:0] ResEdge       = 3'd5;

  state_e      state_q, state_d;
  logic [3:0]  px_q, px_d, py_q, py_d, keys_q, keys_d;
  logic [2:0]  result_q, result_d;
  logic        done_q, done_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d, ready_q, ready_d;
  logic [7:0]  addr_q, addr_d;

  logic [3:0]  nx, ny;
  logic        off_map;
  logic        is_wall, is_key, is_door;

  assign is_wall = (map_rd_data >= WALL_LO) && (map_rd_data <= WALL_HI);
  assign is_key  = (map_rd_data >= KEY_LO)  && (map_rd_data <= KEY_HI);
  assign is_door = (map_rd_data >= DOOR_LO) && (map_rd_data <= DOOR_HI);

  always_comb begin
    nx      = px_q;
    ny      = py_q;
    off_map = 1'b0;
    unique case (move_dir)
      2'd0: begin off_map = (py_q == 4'd0);  ny = py_q - 4'd1; end
      2'd1: begin off_map = (py_q == 4'd15); ny = py_q + 4'd1; end
      2'd2: begin off_map = (px_q == 4'd0);  nx = px_q - 4'd1; end
      2'd3: begin off_map = (px_q == 4'd15); nx = px_q + 4'd1; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    keys_d   = keys_q;
    result_d = result_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    rd_en_d  = 1'b0;
    wr_en_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // level_load wins over a simultaneous move command
        if (level_load) begin
          px_d   = START_X;
          py_d   = START_Y;
          keys_d = 4'd0;
        end else if (move_valid) begin
          if (off_map) begin
            result_d = ResEdge;
            done_d   = 1'b1;
            state_d  = StApply;
          end else begin
            addr_d  = {ny, nx};
            rd_en_d = 1'b1;
            state_d = StRead;
          end
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        done_d  = 1'b1;
        state_d = StApply;
        if (is_wall) begin
          result_d = ResWall;
        end else if (is_key) begin
          px_d     = addr_q[3:0];
          py_d     = addr_q[7:4];
          keys_d   = (keys_q == 4'd15) ? keys_q : keys_q + 4'd1;
          wr_en_d  = 1'b1;
          result_d = ResKey;
        end else if (is_door) begin
          if (keys_q != 4'd0) begin
            px_d     = addr_q[3:0];
            py_d     = addr_q[7:4];
            keys_d   = keys_q - 4'd1;
            wr_en_d  = 1'b1;
            result_d = ResDoorOpen;
          end else begin
            result_d = ResDoorLocked;
          end
        end else begin
          px_d     = addr_q[3:0];
          py_d     = addr_q[7:4];
          result_d = ResMoved;
        end
      end
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      px_q     <= START_X;
      py_q     <= START_Y;
      keys_q   <= 4'd0;
      result_q <= ResMoved;
      addr_q   <= 8'd0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      keys_q   <= keys_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      ready_q  <= ready_d;
    end
  end

  assign move_ready  = ready_q;
  assign map_addr    = addr_q;
  assign map_rd_en   = rd_en_q;
  assign map_wr_en   = wr_en_q;
  assign map_wr_data = FLOOR_ID;
  assign player_x    = px_q;
  assign player_y    = py_q;
  assign key_num     = keys_q;
  assign done        = done_q;
  assign result      = result_q;

endmodule
